bin2seg_seq: RTL
================

Name: bin2seg_seq

Overview:
Parametrised successor to the two-digit 7-segment decoder. Converts an IN_W-bit unsigned binary value into DIGITS 9-bit segment words for the common-cathode display, using iterative double-dabble (shift-add-3), one bit per clock. Adds a start/busy/done handshake, leading-zero blanking and overflow indication. Sits between counter/arithmetic blocks and the display drivers.

Parameters:
IN_W, 8, input value width (1..26)
DIGITS, 3, number of decimal digits/segment words (1..8)

Ports:
clk  in  1  system clock
rst  in  1  reset
start  in  1  request conversion of value; accepted only in IDLE
value  in  IN_W  unsigned binary operand, sampled with accepted start
blank_lz  in  1  1 = blank leading zero digits; sampled with accepted start
busy  out  1  high while conversion in progress
done  out  1  one-cycle pulse; seg_o/overflow valid and updated this cycle
overflow  out  1  last conversion had value >= 10**DIGITS
seg_o  out  9*DIGITS  packed segment words; seg_o[8:0] = least significant digit

Behaviour:
- One clock (clk); reset (rst) is synchronous and active-high.
- Segment word: bits[6:0] = a..g, bit7 = DP (always 0), bit8 = digit disable (1 = digit off). Glyphs 0-9: 3f,06,5b,4f,66,6d,7d,07,7f,6f; dash = 040; blank = 100.
- Reset: state IDLE, busy=0, done=0, overflow=0, every seg_o word = 100 (blank). Reset mid-conversion aborts it, no done pulse.
- FSM states IDLE, SHIFT, OUT.
- IDLE: start=1 in cycle T -> latch value into shift register, clear BCD register (4*DIGITS bits), latch blank_lz, latch ovf = (value >= 10**DIGITS), bit counter = IN_W-1, go SHIFT, busy=1 from T+1.
- SHIFT: each cycle, every BCD nibble >= 5 gets +3, then {bcd,shift} shifts left 1. After IN_W cycles (T+1..T+IN_W) go OUT. Nibble add-3 and shift happen in the same cycle.
- OUT (cycle T+IN_W+1): register seg_o and overflow, done=1, busy=0, return IDLE. Latency start->done = IN_W+1 cycles (9 for IN_W=8).
- Overflow: every digit word = 040, overflow=1. Blanking is ignored in this case.
- Blanking (blank_lz=1, no overflow): digits above the most significant non-zero digit = 100. Digit 0 is never blanked, so value 0 shows a single "0".
- start while busy (SHIFT/OUT) is ignored with no effect. start in the IDLE cycle right after OUT is accepted (back-to-back period IN_W+2).
- seg_o/overflow hold their last value between conversions. Changing value or blank_lz outside an accepted start has no effect.
- Comparison constant 10**DIGITS is computed at elaboration with 32-bit width.

Decomposition:
- Shared package seg7_pkg: SEG_W=9, glyph constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK, and the FSM state typedef.
- One sub-module seg7_lut: combinational 4-bit BCD -> 9-bit glyph, with nibbles >9 mapped to SEG_DASH. Instantiated DIGITS times via generate.

Test Plan:
- IN_W=8, DIGITS=3, value=255, blank_lz=0, start at T -> done pulse only at T+9; seg_o words {d2,d1,d0} = {5b,6d,6d}; overflow=0.
- value=0, blank_lz=1 -> seg_o = {100,100,3f}. Repeat with blank_lz=0 -> {3f,3f,3f}.
- value=7, blank_lz=1 -> {100,100,07}. Then value=105, blank_lz=1 -> {06,3f,6d} (inner zero not blanked).
- DIGITS=2, value=100 -> seg_o={040,040}, overflow=1. Next value=99 -> {6f,6f}, overflow=0.
- start re-asserted every cycle with changing value during busy -> exactly one done per IN_W+2 cycles; results match values sampled only at accepted starts.
- rst=1 at T+4 of a conversion -> next cycle busy=0, seg_o all 100, no done. A fresh start then converts correctly.

Source files
------------

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment display decoders.
//   SEG_W       : width of one segment word {disable, dp, g..a}
//   SEG_0..9    : common-cathode glyphs for the decimal digits
//   SEG_DASH    : middle bar only, used for overflow and non-decimal nibbles
//   SEG_BLANK   : digit-disable bit set, all segments off
//   state_t     : conversion FSM states
//   add3        : double-dabble nibble correction
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam int SEG_W = 9;

    localparam logic [SEG_W-1:0] SEG_0     = 9'h03f;
    localparam logic [SEG_W-1:0] SEG_1     = 9'h006;
    localparam logic [SEG_W-1:0] SEG_2     = 9'h05b;
    localparam logic [SEG_W-1:0] SEG_3     = 9'h04f;
    localparam logic [SEG_W-1:0] SEG_4     = 9'h066;
    localparam logic [SEG_W-1:0] SEG_5     = 9'h06d;
    localparam logic [SEG_W-1:0] SEG_6     = 9'h07d;
    localparam logic [SEG_W-1:0] SEG_7     = 9'h007;
    localparam logic [SEG_W-1:0] SEG_8     = 9'h07f;
    localparam logic [SEG_W-1:0] SEG_9     = 9'h06f;
    localparam logic [SEG_W-1:0] SEG_DASH  = 9'h040;
    localparam logic [SEG_W-1:0] SEG_BLANK = 9'h100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    // A nibble of 5 or more becomes >= 8 after +3, so the following left
    // shift carries it into the next decimal digit.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/seg7_lut.sv
// -----------------------------------------------------------------------------
// seg7_lut
// Combinational BCD digit to segment word decoder.
//   bcd  in  4      BCD digit; values above 9 decode to a dash
//   seg  out SEG_W  segment word {disable, dp, g..a}
// -----------------------------------------------------------------------------
module seg7_lut
    import seg7_pkg::*;
(
    input  logic [3:0]       bcd,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bin2seg_seq.sv
// -----------------------------------------------------------------------------
// bin2seg_seq
// Sequential binary to multi-digit 7-segment converter. Uses double-dabble,
// one input bit per clock, with a start/busy/done handshake, optional
// leading-zero blanking and overflow indication (all digits dashed).
//   clk       in   1          system clock
//   rst       in   1          synchronous active-high reset
//   start     in   1          begin a conversion; honoured only when idle
//   value     in   IN_W       unsigned operand, sampled with accepted start
//   blank_lz  in   1          blank leading zero digits, sampled with start
//   busy      out  1          conversion in progress (shift phase)
//   done      out  1          one-cycle pulse, seg_o/overflow valid
//   overflow  out  1          last conversion had value >= 10**DIGITS
//   seg_o     out  9*DIGITS   segment words, seg_o[8:0] = least significant
// -----------------------------------------------------------------------------
module bin2seg_seq
    import seg7_pkg::*;
#(
    parameter int IN_W   = 8,
    parameter int DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [IN_W-1:0]         value,
    input  logic                    blank_lz,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [SEG_W*DIGITS-1:0] seg_o
);

    localparam int          BCD_W = 4 * DIGITS;
    localparam int          CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [31:0] LIMIT = 32'(10 ** DIGITS);

    state_t state, state_nxt;

    logic [IN_W-1:0]         shreg;
    logic [BCD_W-1:0]        bcd;
    logic [BCD_W-1:0]        bcd_adj;
    logic [BCD_W-1:0]        bcd_nxt;
    logic [CNT_W-1:0]        cnt;
    logic                    blz;
    logic                    ovf;
    logic                    accept;
    logic                    last_shift;
    logic [DIGITS-1:0]       lead_zero;
    logic [SEG_W-1:0]        glyph [DIGITS];
    logic [SEG_W*DIGITS-1:0] seg_nxt;

    assign accept     = (state == S_IDLE) && start;
    assign last_shift = (state == S_SHIFT) && (cnt == '0);

    // ---- FSM: state register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- FSM: next state ----
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start)      state_nxt = S_SHIFT;
            S_SHIFT: if (cnt == '0)  state_nxt = S_OUT;
            S_OUT:                   state_nxt = S_IDLE;
            default:                 state_nxt = S_IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        busy = (state == S_SHIFT);
        done = (state == S_OUT);
    end

    // ---- Double-dabble step: add-3 correction then shift in next bit ----
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            bcd_adj[4*i +: 4] = add3(bcd[4*i +: 4]);
        end
        bcd_nxt = {bcd_adj[BCD_W-2:0], shreg[IN_W-1]};
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            shreg <= value;
            bcd   <= '0;
            blz   <= blank_lz;
            ovf   <= (32'(value) >= LIMIT);
            cnt   <= CNT_W'(IN_W - 1);
        end else if (state == S_SHIFT) begin
            shreg <= shreg << 1;
            bcd   <= bcd_nxt;
            cnt   <= cnt - 1'b1;
            // A carry out of the top digit can only happen when the value
            // does not fit; folding it in keeps both overflow sources aligned.
            ovf   <= ovf | bcd_adj[BCD_W-1];
        end
    end

    // ---- Glyph decode and blanking of the final BCD value ----
    for (genvar g = 0; g < DIGITS; g++) begin : g_lut
        seg7_lut u_lut (
            .bcd (bcd_nxt[4*g +: 4]),
            .seg (glyph[g])
        );
    end

    // lead_zero[i] = digit i and every digit above it are zero.
    always_comb begin
        lead_zero = '0;
        lead_zero[DIGITS-1] = (bcd_nxt[4*(DIGITS-1) +: 4] == 4'd0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            lead_zero[i] = lead_zero[i+1] && (bcd_nxt[4*i +: 4] == 4'd0);
        end
    end

    always_comb begin
        seg_nxt = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (ovf) begin
                seg_nxt[SEG_W*i +: SEG_W] = SEG_DASH;
            end else if (blz && (i != 0) && lead_zero[i]) begin
                seg_nxt[SEG_W*i +: SEG_W] = SEG_BLANK;
            end else begin
                seg_nxt[SEG_W*i +: SEG_W] = glyph[i];
            end
        end
    end

    // ---- Result registers ----
    // Loaded on the edge that ends the last shift, decoding the post-shift
    // BCD value, so the result is already stable in the cycle done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_o    <= {DIGITS{SEG_BLANK}};
            overflow <= 1'b0;
        end else if (last_shift) begin
            seg_o    <= seg_nxt;
            overflow <= ovf | bcd_adj[BCD_W-1];
        end
    end

endmodule
